// File: rtl/fb_pkg.sv
// Shared types and default geometry for the 12-bit frame buffer write path.
package fb_pkg;

    localparam int H_PIXELS  = 320;
    localparam int V_PIXELS  = 240;
    localparam int FB_PIXELS = H_PIXELS * V_PIXELS;
    localparam int FB_ADDR_W = 17;

    // Incoming 10-bit-per-channel pixel, R in the top bits.
    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } rgb101010_t;

    // Stored 4-bit-per-channel pixel, R in the top bits.
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        DISCARD = 2'd2
    } fbw_state_e;

endpackage

// File: rtl/rgb_quantizer.sv
// Combinational RGB101010 -> RGB444 reduction by keeping the top four bits of
// each channel. The display side re-expands with {n, n, 2'b00}, so truncation
// is the exact inverse for every value that expansion can produce.
module rgb_quantizer
    import fb_pkg::*;
(
    input  logic [29:0] pix_in,
    output logic [11:0] pix_out
);

    rgb101010_t pix_wide;
    rgb444_t    pix_narrow;
    logic       unused_lsbs;

    assign pix_wide = rgb101010_t'(pix_in);

    // Keep the four most significant bits of every channel.
    always_comb begin
        pix_narrow.r = pix_wide.r[9:6];
        pix_narrow.g = pix_wide.g[9:6];
        pix_narrow.b = pix_wide.b[9:6];
    end

    assign pix_out     = pix_narrow;
    assign unused_lsbs = ^{pix_wide.r[5:0], pix_wide.g[5:0], pix_wide.b[5:0]};

endmodule

// File: rtl/frame_buffer_writer.sv
// Write side of the double-buffered 12-bit frame buffer. Frames are written
// into the back bank (~display_bank); the banks swap only when a frame of
// exactly H_PIXELS*V_PIXELS pixels ends with its end-of-frame marker.
module frame_buffer_writer #(
    parameter int H_PIXELS = fb_pkg::H_PIXELS,
    parameter int V_PIXELS = fb_pkg::V_PIXELS,
    parameter int ADDR_W   = fb_pkg::FB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [29:0]       in_data,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              in_ready,
    output logic [ADDR_W:0]   wr_addr,
    output logic [11:0]       wr_data,
    output logic              wr_en,
    output logic              display_bank,
    output logic              frame_done,
    output logic              frame_error,
    output logic [15:0]       frame_count
);

    import fb_pkg::*;

    localparam int                N        = H_PIXELS * V_PIXELS;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

    fbw_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pix_idx_q, pix_idx_d;
    logic [11:0]       pix_q;
    logic              beat;
    logic              start;
    logic              good_end;
    logic              wr_en_d;
    logic [ADDR_W:0]   wr_addr_d;
    logic [11:0]       wr_data_d;
    logic              done_d;
    logic              error_d;
    logic              bank_d;
    logic [15:0]       count_d;

    rgb_quantizer u_quant (
        .pix_in  (in_data),
        .pix_out (pix_q)
    );

    assign beat = in_valid & in_ready;

    // Frame sequencing: decide the next state, the write to issue and the
    // frame-level status pulses for the beat presented this cycle.
    always_comb begin
        state_d   = state_q;
        pix_idx_d = pix_idx_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        done_d    = 1'b0;
        error_d   = 1'b0;
        bank_d    = display_bank;
        count_d   = frame_count;
        start     = 1'b0;
        good_end  = 1'b0;

        case (state_q)
            IDLE: begin
                start = beat & in_sop & enable;
            end
            WRITE: begin
                if (beat) begin
                    if (in_sop) begin
                        // A new frame overrides the open one.
                        start   = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {~display_bank, pix_idx_q};
                        wr_data_d = pix_q;
                        if (in_eop) begin
                            state_d = IDLE;
                            if (pix_idx_q == LAST_IDX) good_end = 1'b1;
                            else                       error_d  = 1'b1;
                        end else if (pix_idx_q == LAST_IDX) begin
                            state_d = DISCARD;
                        end else begin
                            pix_idx_d = pix_idx_q + 1'b1;
                        end
                    end
                end
            end
            DISCARD: begin
                if (beat) begin
                    if (in_eop) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end else if (in_sop) begin
                        start   = 1'b1;
                        error_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Frame start: the first pixel always lands at index 0 of the back bank.
        if (start) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {~display_bank, {ADDR_W{1'b0}}};
            wr_data_d = pix_q;
            if (in_eop) begin
                state_d = IDLE;
                if (N == 1) good_end = 1'b1;
                else        error_d  = 1'b1;
            end else if (N == 1) begin
                state_d   = DISCARD;
                pix_idx_d = '0;
            end else begin
                state_d   = WRITE;
                pix_idx_d = ADDR_W'(1);
            end
        end

        if (good_end) begin
            done_d  = 1'b1;
            bank_d  = ~display_bank;
            count_d = frame_count + 16'd1;
        end
    end

    // State, write port and status registers; the bank swap lands in the same
    // cycle as the write strobe of the final pixel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pix_idx_q    <= '0;
            in_ready     <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            display_bank <= 1'b0;
            frame_done   <= 1'b0;
            frame_error  <= 1'b0;
            frame_count  <= '0;
        end else begin
            state_q      <= state_d;
            pix_idx_q    <= pix_idx_d;
            in_ready     <= 1'b1;
            wr_en        <= wr_en_d;
            wr_addr      <= wr_addr_d;
            wr_data      <= wr_data_d;
            display_bank <= bank_d;
            frame_done   <= done_d;
            frame_error  <= error_d;
            frame_count  <= count_d;
        end
    end

endmodule
